// File: rtl/pll_fbdsel_ctrl.sv
// pll_fbdsel_ctrl: sequences multiplier changes onto the rPLL FBDSEL input.
// Accepts range-checked requests over valid/ready, writes fbdsel = 64 - mult,
// then holds off for a settle window before reporting the clock as stable.
// Optional build macro: PLL_FBDSEL_CTRL_SLEW_EN steps the multiplier one unit
// at a time toward the target, settling after every step.
module pll_fbdsel_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter int unsigned RESET_MULT    = 8,
  parameter int unsigned MIN_MULT      = 1,
  parameter int unsigned MAX_MULT      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [6:0] req_mult,
  output logic       req_ready,
  output logic [5:0] fbdsel,
  output logic [6:0] cur_mult,
  output logic       stable,
  output logic       done,
  output logic       err
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [6:0]    RST_M    = 7'(RESET_MULT);
  localparam logic [6:0]    MIN_M    = 7'(MIN_MULT);
  localparam logic [6:0]    MAX_M    = 7'(MAX_MULT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] APPLY  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  // FBDSEL encoding; only meaningful for mult in 1..64.
  function automatic logic [5:0] enc(input logic [6:0] m);
    return 6'(7'd64 - m);
  endfunction

  logic [1:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [6:0]    cur_q,    cur_d;
  logic [6:0]    target_q, target_d;
  logic [5:0]    fbdsel_q, fbdsel_d;
  logic          ready_q,  ready_d;
  logic          stable_q, stable_d;
  logic          done_q,   done_d;
  logic          err_q,    err_d;
  logic          boot_q,   boot_d;

  // Next-state logic for the IDLE -> APPLY -> SETTLE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    target_d = target_q;
    fbdsel_d = fbdsel_q;
    ready_d  = ready_q;
    stable_d = stable_q;
    boot_d   = boot_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          if ((req_mult < MIN_M) || (req_mult > MAX_M)) begin
            err_d = 1'b1;
          end else if (req_mult == cur_q) begin
            done_d = 1'b1;
          end else begin
            target_d = req_mult;
            state_d  = APPLY;
            ready_d  = 1'b0;
            stable_d = 1'b0;
          end
        end
      end
      APPLY: begin
`ifdef PLL_FBDSEL_CTRL_SLEW_EN
        // APPLY is only entered with cur != target, so a step is always taken.
        cur_d = (target_q > cur_q) ? cur_q + 7'd1 : cur_q - 7'd1;
`else
        cur_d = target_q;
`endif
        fbdsel_d = enc(cur_d);
        cnt_d    = CNT_INIT;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
`ifdef PLL_FBDSEL_CTRL_SLEW_EN
          if (cur_q != target_q) begin
            state_d = APPLY;
          end else begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            stable_d = 1'b1;
            done_d   = ~boot_q;
            boot_d   = 1'b0;
          end
`else
          state_d  = IDLE;
          ready_d  = 1'b1;
          stable_d = 1'b1;
          done_d   = ~boot_q;
          boot_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = SETTLE;
        cnt_d    = CNT_INIT;
        ready_d  = 1'b0;
        stable_d = 1'b0;
      end
    endcase
  end

  // State registers; reset restarts a full settle at the reset multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SETTLE;
      cnt_q    <= CNT_INIT;
      cur_q    <= RST_M;
      target_q <= RST_M;
      fbdsel_q <= enc(RST_M);
      ready_q  <= 1'b0;
      stable_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      boot_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      fbdsel_q <= fbdsel_d;
      ready_q  <= ready_d;
      stable_q <= stable_d;
      done_q   <= done_d;
      err_q    <= err_d;
      boot_q   <= boot_d;
    end
  end

  assign req_ready = ready_q;
  assign fbdsel    = fbdsel_q;
  assign cur_mult  = cur_q;
  assign stable    = stable_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pll_fbdsel_ctrl.sv
// Directed bench for pll_fbdsel_ctrl with a completion-event scoreboard.
module tb_pll_fbdsel_ctrl;

  localparam int unsigned SC = 16;

  typedef struct packed {
    logic       is_err;
    logic [5:0] fb;
    logic [6:0] cur;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [6:0] req_mult;
  logic       req_ready;
  logic [5:0] fbdsel;
  logic [6:0] cur_mult;
  logic       stable;
  logic       done;
  logic       err;

  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];
  ev_t ev;

  always #5 clk = ~clk;

  pll_fbdsel_ctrl #(
    .SETTLE_CYCLES(SC),
    .RESET_MULT   (8),
    .MIN_MULT     (1),
    .MAX_MULT     (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_mult (req_mult),
    .req_ready(req_ready),
    .fbdsel   (fbdsel),
    .cur_mult (cur_mult),
    .stable   (stable),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic is_err, input logic [5:0] fb, input logic [6:0] cur);
    ev_t e;
    e.is_err = is_err;
    e.fb     = fb;
    e.cur    = cur;
    exp_q.push_back(e);
  endtask

  // Present a request and return just after the edge on which it was accepted.
  task automatic handshake(input logic [6:0] m);
    req_mult  = m;
    req_valid = 1'b1;
    for (int w = 0; w < 200 && req_ready !== 1'b1; w++) tick();
    check("hs_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  // Settle after reset: stable/ready low for SC cycles, then high, no done.
  task automatic reset_settle();
    for (int k = 1; k <= SC; k++) begin
      tick();
      check("rs_stable", stable, (k == SC));
      check("rs_ready", req_ready, (k == SC));
      check("rs_done", done, 1'b0);
      check("rs_fbdsel", fbdsel, 6'd56);
    end
  endtask

  // Called just after a jumping handshake edge; follows APPLY + SETTLE.
  task automatic settle_run(input logic [5:0] fb, input logic [6:0] cm);
    check("sr_stable0", stable, 1'b0);
    check("sr_ready0", req_ready, 1'b0);
    tick();
    check("sr_fbdsel", fbdsel, fb);
    check("sr_cur", cur_mult, cm);
    for (int k = 2; k <= SC + 1; k++) begin
      tick();
      check("sr_done", done, (k == SC + 1));
      check("sr_stable", stable, (k == SC + 1));
      check("sr_ready", req_ready, (k == SC + 1));
      check("sr_fbdsel_hold", fbdsel, fb);
    end
  endtask

  // Scoreboard: each done/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (done === 1'b1 || err === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt", {30'd0, done, err}, 32'd0);
      end else begin
        ev = exp_q.pop_front();
        check("evt_kind", {30'd0, done, err}, ev.is_err ? 32'd1 : 32'd2);
        check("evt_fbdsel", fbdsel, ev.fb);
        check("evt_cur", cur_mult, ev.cur);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_mult  = 7'd0;
    tick();
    tick();
    check("rst_fbdsel", fbdsel, 6'd56);
    check("rst_cur", cur_mult, 7'd8);
    check("rst_stable", stable, 1'b0);
    check("rst_ready", req_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    reset_settle();

`ifdef PLL_FBDSEL_CTRL_SLEW_EN
    push_ev(1'b0, 6'd53, 7'd11);
    handshake(7'd11);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("slew_fbdsel", fbdsel, 6'(55 - s));
      check("slew_stable_apply", stable, 1'b0);
      for (int j = 1; j <= SC; j++) begin
        tick();
        check("slew_done", done, (s == 2 && j == SC));
        check("slew_stable", stable, (s == 2 && j == SC));
      end
    end
    check("slew_cur", cur_mult, 7'd11);
`else
    // Normal jump to 20.
    push_ev(1'b0, 6'd44, 7'd20);
    handshake(7'd20);
    check("m20_fbdsel_early", fbdsel, 6'd56);
    settle_run(6'd44, 7'd20);

    // Out-of-range requests.
    push_ev(1'b1, 6'd44, 7'd20);
    handshake(7'd0);
    check("lo_err", err, 1'b1);
    check("lo_done", done, 1'b0);
    check("lo_stable", stable, 1'b1);
    check("lo_fbdsel", fbdsel, 6'd44);
    tick();
    check("lo_err_pulse", err, 1'b0);
    push_ev(1'b1, 6'd44, 7'd20);
    handshake(7'd65);
    check("hi_err", err, 1'b1);
    check("hi_stable", stable, 1'b1);
    check("hi_cur", cur_mult, 7'd20);
    tick();
    check("hi_err_pulse", err, 1'b0);

    // Same multiplier: immediate done, no settle.
    push_ev(1'b0, 6'd44, 7'd20);
    handshake(7'd20);
    check("eq_done", done, 1'b1);
    check("eq_stable", stable, 1'b1);
    check("eq_ready", req_ready, 1'b1);
    tick();
    check("eq_done_pulse", done, 1'b0);
    check("eq_stable2", stable, 1'b1);

    // Request held through a settle window is taken once, afterwards.
    push_ev(1'b0, 6'd39, 7'd25);
    handshake(7'd25);
    req_mult  = 7'd30;
    req_valid = 1'b1;
    push_ev(1'b0, 6'd34, 7'd30);
    settle_run(6'd39, 7'd25);
    tick();
    req_valid = 1'b0;
    settle_run(6'd34, 7'd30);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hold_once_stable", stable, 1'b1);
    end

    // Reset mid-settle (cnt == 5).
    handshake(7'd40);
    for (int k = 1; k <= 11; k++) tick();
    check("mid_fbdsel", fbdsel, 6'd24);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_fbdsel", fbdsel, 6'd56);
    check("mid_rst_cur", cur_mult, 7'd8);
    check("mid_rst_stable", stable, 1'b0);
    reset_settle();

    // Encoding boundaries.
    push_ev(1'b0, 6'd63, 7'd1);
    handshake(7'd1);
    settle_run(6'd63, 7'd1);
    push_ev(1'b0, 6'd0, 7'd64);
    handshake(7'd64);
    settle_run(6'd0, 7'd64);
`endif

    for (int k = 0; k < 4; k++) tick();
    check("queue_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
